// File: rtl/jk_excite_driver.sv
// Buffers target states for an external J-K flop bank and emits the J/K excitation that moves it there.
// Define JK_TOGGLE_EN to drive changing bits with J=K=1 (toggle) instead of set/reset encoding.
module jk_excite_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           tgt,
    input  logic                       tgt_valid,
    output logic                       tgt_ready,
    input  logic                       adv,
    output logic [WIDTH-1:0]           j_out,
    output logic [WIDTH-1:0]           k_out,
    output logic                       jk_valid,
    input  logic [WIDTH-1:0]           q_fb,
    output logic [WIDTH-1:0]           q_shadow,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] j_next;
    logic [WIDTH-1:0] k_next;
    logic [WIDTH-1:0] exp_q;
    logic             chk;

    assign tgt_ready = (level != FULL);
    assign push      = tgt_valid && tgt_ready;
    assign pop       = adv && (level != '0);
    assign head      = mem[rd_ptr];

    // Inverse J-K characteristic: only bits that change state need a non-zero J/K.
    always_comb begin
        j_next = '0;
        k_next = '0;
`ifdef JK_TOGGLE_EN
        j_next = q_shadow ^ head;
        k_next = q_shadow ^ head;
`else
        j_next = ~q_shadow & head;
        k_next = q_shadow & ~head;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Outputs hold between pops; jk_valid marks the single cycle the flops should be clocked.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            j_out    <= '0;
            k_out    <= '0;
            jk_valid <= 1'b0;
            q_shadow <= '0;
        end else begin
            jk_valid <= pop;
            if (pop) begin
                j_out    <= j_next;
                k_out    <= k_next;
                q_shadow <= head;
            end
        end
    end

    // The flops latch one edge after jk_valid, so their Q is compared one edge later still.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            exp_q <= '0;
            chk   <= 1'b0;
            err   <= 1'b0;
        end else begin
            chk <= jk_valid;
            if (jk_valid) begin
                exp_q <= q_shadow;
            end
            if (chk && (q_fb != exp_q)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/jk_excite_driver.md
# jk_excite_driver

Generates J/K excitation vectors that drive a bank of WIDTH external asynchronous-clear J-K flip-flops through a requested sequence of target states. It applies the inverse of the J-K characteristic table. Target words arrive over a valid/ready handshake and are buffered in a small FIFO. Each one is released on an `adv` strobe as a registered J/K pair. A shadow copy of the flop state checks the flops' fed-back Q against the expected value.

## Interface
- `WIDTH`, default 4: number of J-K flip-flops driven (1..32).
- `DEPTH`, default 4: target FIFO entries, power of two (2..16).

- `clk`  in  1: clock, rising edge.
- `clr`  in  1: reset, asynchronous, active-high.
- `tgt`  in  WIDTH: requested next flop state.
- `tgt_valid`  in  1: `tgt` is valid.
- `tgt_ready`  out  1: FIFO can accept a word.
- `adv`  in  1: release one target when FIFO non-empty.
- `j_out`  out  WIDTH: J inputs for the flop bank.
- `k_out`  out  WIDTH: K inputs for the flop bank.
- `jk_valid`  out  1: `j_out`/`k_out` hold a fresh excitation this cycle.
- `q_fb`  in  WIDTH: Q outputs of the flop bank.
- `q_shadow`  out  WIDTH: expected flop state after the last emitted excitation.
- `err`  out  1: sticky feedback-mismatch flag.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Reset values.** `clr` high sets the following: `j_out`=0, `k_out`=0, `jk_valid`=0, `q_shadow`=0 (matches flop clear value 0), `err`=0, `level`=0, FIFO pointers=0, check pipeline cleared. `tgt_ready`=1 once `clr` deasserts.
- **Push.** A push occurs when `tgt_valid && tgt_ready`. `tgt_ready` = (`level` != DEPTH). It is combinational from the registered level only.
- **Pop.** A pop occurs when `adv && level != 0`. `adv` with an empty FIFO is ignored: `jk_valid`=0 next cycle and the J/K outputs retain their previous value.
- **Simultaneous push and pop.** Both happen and `level` is unchanged. A push into an empty FIFO cannot pop in the same cycle; there is no bypass.
- **Excitation per bit**, with s = `q_shadow`[i] and t = popped `tgt`[i]:
  - 0→0: J=0, K=0
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - 1→1: J=0, K=0
- **Shadow update.** On a pop, `q_shadow` <= `tgt`.
- **Non-pop cycles.** `j_out` and `k_out` are held, and `jk_valid`=0. The external flops are expected to be clocked only while `jk_valid` is high. Holding the outputs is otherwise harmless only for 00 patterns.
- **Feedback check.** This is a two-stage pipeline:
  - On the edge where `jk_valid`=1: capture `exp` <= `q_shadow` and set `chk`=1.
  - On the next edge with `chk`=1: if `q_fb` != `exp`, set `err`.
  - `err` clears only on `clr`.
  - Back-to-back pops pipeline their checks independently.
- **Mid-operation `clr`.** Flushes FIFO contents and pending checks, with no partial excitation.

## Timing
- Push edge to earliest pop: 1 cycle, so `adv` is honoured on the edge after the push edge.
- Pop edge: `j_out`, `k_out`, `jk_valid` and `q_shadow` update on this same edge (registered outputs).
- Flop sample: the external flops latch on the next edge, E+1.
- Check: `q_fb` is compared at E+2, and `err` is visible after E+2.
- Sustained throughput: one excitation per cycle.

## Configuration
- `JK_TOGGLE_EN`, defined: bits that change state use J=1, K=1 (toggle) instead of set/reset encoding. Unchanged bits remain J=0, K=0.
- `JK_TOGGLE_EN`, undefined: set/reset encoding as in Operation.
- The macro has no effect on `q_shadow`, the check pipeline or timing.

## Test plan
- **Reset state.** Assert `clr` mid-run with `level`=3. Required: all outputs reset, `level`=0, `tgt_ready`=1, and no `jk_valid` until a new push and pop.
- **Basic excitation** (WIDTH=4). Push 4'b1010, then `adv`. Required: `j_out`=1010, `k_out`=0000, `q_shadow`=1010. Then push 4'b0110 and `adv`. Required: `j_out`=0100, `k_out`=1000. With `JK_TOGGLE_EN`: `j_out`=`k_out`=1100.
- **Full and empty.** Push DEPTH words without `adv`. Required: `tgt_ready`=0 and an extra `tgt_valid` is not accepted. Then drain with DEPTH+1 `adv` strobes. Required: exactly DEPTH `jk_valid` pulses, in push order, and `level`=0.
- **Simultaneous push and pop** at `level`=2 for 10 cycles. Required: `level` stays at 2 and the output order matches the input order.
- **Closed loop.** Drive an ideal JK-FF bank model from `j_out`/`k_out`, clocked on `jk_valid`, with a random 50-target stream. Required: `err`=0 and `q_fb`==`q_shadow` two cycles after each pop.
- **Fault.** Force `q_fb`[2] stuck at 0 and emit a target with bit 2 = 1. Required: `err` rises exactly 2 edges after the pop edge and stays high until `clr`.
